// File: rtl/pio_event_master_pkg.sv
// rtl/pio_event_master_pkg.sv - shared constants, FSM encoding and bus helpers for pio_event_master
//   No ports. Provides:
//     TS_WIDTH                     timestamp width (32)
//     PIO_DATA/MASK/OUTSET/OUTCLR  PIO s1 register addresses
//     state_e                      FSM state enum (encodings pinned by ST_* constants)
//     avm_cmd_t, avm_idle/rd/wr    one-cycle Avalon-MM command builders

package pio_event_master_pkg;

  localparam int TS_WIDTH = 32;

  localparam logic [2:0] PIO_DATA   = 3'd0;
  localparam logic [2:0] PIO_MASK   = 3'd2;
  localparam logic [2:0] PIO_OUTSET = 3'd4;
  localparam logic [2:0] PIO_OUTCLR = 3'd5;

  // Fixed encodings so existing debug taps on the state register keep working.
  localparam logic [3:0] ST_ARM       = 4'd0;
  localparam logic [3:0] ST_IDLE      = 4'd1;
  localparam logic [3:0] ST_RD_REQ    = 4'd2;
  localparam logic [3:0] ST_RD_WAIT   = 4'd3;
  localparam logic [3:0] ST_CAPTURE   = 4'd4;
  localparam logic [3:0] ST_LED_SET   = 4'd5;
  localparam logic [3:0] ST_HOLD      = 4'd6;
  localparam logic [3:0] ST_POLL_REQ  = 4'd7;
  localparam logic [3:0] ST_POLL_WAIT = 4'd8;
  localparam logic [3:0] ST_POLL_CHK  = 4'd9;
  localparam logic [3:0] ST_LED_CLR   = 4'd10;

  typedef enum logic [3:0] {
    S_ARM       = ST_ARM,
    S_IDLE      = ST_IDLE,
    S_RD_REQ    = ST_RD_REQ,
    S_RD_WAIT   = ST_RD_WAIT,
    S_CAPTURE   = ST_CAPTURE,
    S_LED_SET   = ST_LED_SET,
    S_HOLD      = ST_HOLD,
    S_POLL_REQ  = ST_POLL_REQ,
    S_POLL_WAIT = ST_POLL_WAIT,
    S_POLL_CHK  = ST_POLL_CHK,
    S_LED_CLR   = ST_LED_CLR
  } state_e;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
  } avm_cmd_t;

  function automatic avm_cmd_t avm_idle();
    return '{cs: 1'b0, write_n: 1'b1, address: 3'd0, writedata: 32'd0};
  endfunction

  function automatic avm_cmd_t avm_rd(input logic [2:0] addr);
    return '{cs: 1'b1, write_n: 1'b1, address: addr, writedata: 32'd0};
  endfunction

  function automatic avm_cmd_t avm_wr(input logic [2:0] addr, input logic [31:0] data);
    return '{cs: 1'b1, write_n: 1'b0, address: addr, writedata: data};
  endfunction

endpackage

// File: rtl/pio_event_master_if.sv
// rtl/pio_event_master_if.sv - Avalon-MM link to the PIO s1 port plus its interrupt
//   avm_address    [2:0]  PIO register address
//   avm_chipselect        PIO select
//   avm_write_n           write strobe, active-low
//   avm_writedata  [31:0] write data
//   avm_readdata   [31:0] read data, one-cycle fixed latency, no waitrequest
//   irq                   PIO interrupt, level
//   modport master: the event master side; modport slave: the PIO side

interface pio_event_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, irq
  );
endinterface

// File: rtl/pio_event_master_evt_fifo.sv
// rtl/pio_event_master_evt_fifo.sv - synchronous DEPTH x WIDTH event FIFO
//   clk, reset_n        clock, asynchronous active-low reset
//   push, wdata         write request and data; ignored while full unless popping
//   pop                 read request; ignored while empty
//   rdata               head entry (zero after reset)
//   full, empty         occupancy flags

module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot the push needs.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pio_event_master.sv
// rtl/pio_event_master.sv - services the drum-pad PIO interrupt and timestamps hits into a FIFO
//   clk, reset_n     clock, asynchronous active-low reset
//   avm              Avalon-MM master to PIO s1 plus its irq (pio_event_master_if.master)
//   evt_valid        FIFO head valid
//   evt_ready        consumer accepts the head
//   evt_timestamp    cycle-counter value at the irq of the head event
//   overflow         sticky, set on the first dropped event
//   drop_count       dropped events, saturating at 255
//   busy             FSM not in IDLE

module pio_event_master
  import pio_event_master_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int HOLDOFF_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pio_event_master_if.master      avm,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [TS_WIDTH-1:0]     evt_timestamp,
  output logic                    overflow,
  output logic [7:0]              drop_count,
  output logic                    busy
);

  localparam int            HW          = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLDOFF_CYCLES - 1);

  state_e              state;
  state_e              state_nxt;
  avm_cmd_t            cmd;
  logic [TS_WIDTH-1:0] cycle_cnt;
  logic [TS_WIDTH-1:0] ts_hold;
  logic [HW-1:0]       hold_cnt;
  logic                pad_lvl;
  logic                push_req;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                drop;
  logic                unused_readdata;

  // Only the pad level bit of the data register carries information.
  assign unused_readdata = ^avm.avm_readdata[31:1];

  always_comb begin
    state_nxt = state;
    cmd       = avm_idle();
    push_req  = 1'b0;
    case (state)
      S_ARM: begin
        cmd       = avm_wr(PIO_MASK, 32'd1);
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (avm.irq) state_nxt = S_RD_REQ;
      end
      S_RD_REQ: begin
        cmd       = avm_rd(PIO_DATA);
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (pad_lvl) begin
          // Real hit: mask further interrupts while we hold off.
          cmd       = avm_wr(PIO_MASK, 32'd0);
          push_req  = 1'b1;
          state_nxt = S_LED_SET;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_LED_SET: begin
        cmd       = avm_wr(PIO_OUTSET, 32'd1);
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt == '0) state_nxt = S_POLL_REQ;
      end
      S_POLL_REQ: begin
        cmd       = avm_rd(PIO_DATA);
        state_nxt = S_POLL_WAIT;
      end
      S_POLL_WAIT: state_nxt = S_POLL_CHK;
      S_POLL_CHK:  state_nxt = pad_lvl ? S_HOLD : S_LED_CLR;
      S_LED_CLR: begin
        cmd       = avm_wr(PIO_OUTCLR, 32'd1);
        state_nxt = S_ARM;
      end
      default: state_nxt = S_ARM;
    endcase
  end

  // Bus and busy are decoded from the state register so the ARM write lands in
  // the very first cycle after reset; gating with reset_n keeps them idle while
  // reset is held, even though the state register already sits in ARM.
  assign avm.avm_chipselect = reset_n && cmd.cs;
  assign avm.avm_write_n    = !reset_n || cmd.write_n;
  assign avm.avm_address    = reset_n ? cmd.address   : 3'd0;
  assign avm.avm_writedata  = reset_n ? cmd.writedata : 32'd0;
  assign busy               = reset_n && (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_ARM;
      cycle_cnt <= '0;
      ts_hold   <= '0;
      hold_cnt  <= '0;
      pad_lvl   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cycle_cnt + TS_WIDTH'(1);
      if (state == S_IDLE && avm.irq) begin
        ts_hold <= cycle_cnt;
      end
      // Read data appears in the WAIT cycle; hold it for the decision cycle.
      if (state == S_RD_WAIT || state == S_POLL_WAIT) begin
        pad_lvl <= avm.avm_readdata[0];
      end
      if (state == S_LED_SET || (state == S_POLL_CHK && pad_lvl)) begin
        hold_cnt <= HOLD_RELOAD;
      end else if (state == S_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign drop      = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TS_WIDTH)
  ) u_evt_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .wdata   (ts_hold),
    .pop     (pop),
    .rdata   (evt_timestamp),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_pio_event_master.sv
// tb/tb_pio_event_master.sv - directed self-checking bench for pio_event_master

module tb_pio_event_master;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        evt_ready = 1'b0;
  logic        pad       = 1'b0;
  logic        evt_valid;
  logic [31:0] evt_timestamp;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int tb_cyc;
  int read_cycs[$];

  pio_event_master_if bus();

  pio_event_master #(
    .FIFO_DEPTH     (4),
    .HOLDOFF_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avm           (bus),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_timestamp (evt_timestamp),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: value seen during a cycle equals the DUT counter.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cyc <= 0;
    else          tb_cyc <= tb_cyc + 1;
  end

  // PIO slave model: registered read data, one-cycle latency.
  always @(posedge clk) begin
    if (!reset_n) begin
      bus.avm_readdata <= 32'd0;
    end else if (bus.avm_chipselect && bus.avm_write_n && bus.avm_address == 3'd0) begin
      bus.avm_readdata <= {31'd0, pad};
      read_cycs.push_back(tb_cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] bw(input logic cs, input logic wn,
                                     input logic [2:0] addr, input logic [31:0] data);
    return {27'd0, cs, wn, addr, data};
  endfunction

  function automatic logic [63:0] bus_now();
    return {27'd0, bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      tick(1);
      k++;
    end
    check(tag, busy, 0);
  endtask

  // One clean hit: irq for one cycle with the pad high, pad released at T+5.
  task automatic do_hit(output int ts);
    bus.irq = 1'b1;
    pad     = 1'b1;
    ts      = tb_cyc;
    tick(1);
    bus.irq = 1'b0;
    tick(4);
    pad = 1'b0;
    wait_idle("hit_return_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int ts[6];
    logic [63:0] idle_bus;
    idle_bus = bw(1'b0, 1'b1, 3'd0, 32'd0);
    bus.irq  = 1'b0;
    tick(3);

    check("rst_bus",   bus_now(),     idle_bus);
    check("rst_valid", evt_valid,     0);
    check("rst_ts",    evt_timestamp, 0);
    check("rst_ovf",   overflow,      0);
    check("rst_drop",  drop_count,    0);
    check("rst_busy",  busy,          0);

    reset_n = 1'b1;
    #1;
    check("arm_write", bus_now(), bw(1'b1, 1'b0, 3'd2, 32'd1));
    tick(1);
    check("arm_bus_idle", bus_now(), idle_bus);
    check("arm_busy",     busy,      0);
    tick(2);

    // Hit with pad held high ~30 cycles, HOLDOFF_CYCLES = 8.
    read_cycs.delete();
    bus.irq = 1'b1;
    pad     = 1'b1;
    t0      = tb_cyc;
    tick(1);
    bus.irq = 1'b0;
    check("hit_read_t1", bus_now(), bw(1'b1, 1'b1, 3'd0, 32'd0));
    tick(1);
    check("hit_idle_t2", bus_now(), idle_bus);
    tick(1);
    check("hit_mask0_t3", bus_now(), bw(1'b1, 1'b0, 3'd2, 32'd0));
    check("hit_valid_t3", evt_valid, 0);
    tick(1);
    check("hit_ledset_t4", bus_now(), bw(1'b1, 1'b0, 3'd4, 32'd1));
    check("hit_valid_t4",  evt_valid, 1);
    check("hit_ts",        evt_timestamp, t0);
    tick(26);
    pad = 1'b0;
    tick(8);
    check("led_clr_t38", bus_now(), bw(1'b1, 1'b0, 3'd5, 32'd1));
    tick(1);
    check("rearm_t39", bus_now(), bw(1'b1, 1'b0, 3'd2, 32'd1));
    tick(1);
    check("rearm_busy_t40", busy, 0);
    check("rearm_bus_t40",  bus_now(), idle_bus);
    check("poll_count", read_cycs.size(), 4);
    if (read_cycs.size() == 4) begin
      check("first_poll", read_cycs[1] - t0,           13);
      check("poll_gap_1", read_cycs[2] - read_cycs[1], 11);
      check("poll_gap_2", read_cycs[3] - read_cycs[2], 11);
    end
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    check("single_event", evt_valid, 0);

    // Spurious interrupt: pad reads back 0.
    tick(2);
    bus.irq = 1'b1;
    pad     = 1'b0;
    tick(1);
    bus.irq = 1'b0;
    check("sp_read_t1", bus_now(), bw(1'b1, 1'b1, 3'd0, 32'd0));
    tick(2);
    check("sp_nomask_t3", bus_now(), idle_bus);
    check("sp_busy_t3",   busy, 1);
    tick(1);
    check("sp_idle_t4",   busy, 0);
    check("sp_no_event",  evt_valid, 0);

    // Six hits into a four-deep FIFO with no consumer.
    for (int i = 0; i < 6; i++) begin
      do_hit(ts[i]);
      if (i == 3) begin
        check("full_valid", evt_valid,  1);
        check("full_ovf",   overflow,   0);
        check("full_drop",  drop_count, 0);
      end
      if (i == 4) begin
        check("drop1_ovf",  overflow,   1);
        check("drop1_cnt",  drop_count, 1);
      end
    end
    check("ovf_sticky", overflow,      1);
    check("drop_cnt2",  drop_count,    2);
    check("ovf_head",   evt_timestamp, ts[0]);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop%0d_valid", i), evt_valid,     1);
      check($sformatf("pop%0d_ts", i),    evt_timestamp, ts[i]);
      tick(1);
    end
    check("drained", evt_valid, 0);
    evt_ready = 1'b0;

    // Reset asserted during HOLD.
    tick(1);
    bus.irq = 1'b1;
    pad     = 1'b1;
    tick(1);
    bus.irq = 1'b0;
    tick(7);
    check("hold_busy",  busy,      1);
    check("hold_valid", evt_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_bus",   bus_now(),     idle_bus);
    check("mid_rst_busy",  busy,          0);
    check("mid_rst_valid", evt_valid,     0);
    check("mid_rst_ts",    evt_timestamp, 0);
    check("mid_rst_ovf",   overflow,      0);
    check("mid_rst_drop",  drop_count,    0);
    tick(2);
    reset_n = 1'b1;
    pad     = 1'b0;
    #1;
    check("rearm_after_rst", bus_now(), bw(1'b1, 1'b0, 3'd2, 32'd1));
    tick(1);
    check("idle_after_rst", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pio_event_master.md
# pio_event_master

Avalon-MM master that services the single-bit interrupt PIO on the drum-pad input.
- Arms the PIO interrupt mask, waits for `irq`, reads the PIO data register and timestamps the hit into a small event FIFO.
- Lights the PIO output bit as a hit indicator and masks the interrupt during a debounce hold-off.
- Re-arms once the pad input returns low.
- Sits between the PIO slave's `s1` port and the audio trigger logic; the Nios II does not have to take per-hit interrupts.

## Interface
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, at least 2.
- `HOLDOFF_CYCLES`, 50000: debounce hold-off in clocks (1 ms at 50 MHz); at least 1.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `irq` in 1: PIO interrupt, level.
- `avm_address` out 3: PIO register address.
- `avm_chipselect` out 1: PIO select.
- `avm_write_n` out 1: write strobe, active-low.
- `avm_writedata` out 32: write data.
- `avm_readdata` in 32: PIO read data, registered in the slave with fixed one-cycle latency and no waitrequest.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_timestamp` out 32: timestamp of the head event.
- `overflow` out 1: sticky; set on the first dropped event.
- `drop_count` out 8: dropped events, saturating at 255.
- `busy` out 1: the FSM is not in IDLE.

## Operation
PIO register map:
- 0: data. Read returns pad level in bit 0; write sets `out_port`.
- 2: irq mask.
- 4: bit-set of `out_port`.
- 5: bit-clear of `out_port`.

FSM states and transitions:
- ARM: write addr 2, data 1 → IDLE.
- IDLE: on `irq`=1, latch the free-running 32-bit cycle counter into `ts_hold` → RD_REQ.
- RD_REQ: chipselect=1, write_n=1, addr 0 → RD_WAIT.
- RD_WAIT: idle bus; `avm_readdata` is valid this cycle → CAPTURE.
- CAPTURE: sample `avm_readdata[0]`.
  - If 0 (spurious): → IDLE, nothing pushed.
  - If 1: push `ts_hold` and write addr 2, data 0 → LED_SET.
- LED_SET: write addr 4, data 1 → HOLD. Load the hold-off counter with `HOLDOFF_CYCLES`-1.
- HOLD: decrement the counter; at 0 → POLL_REQ.
- POLL_REQ: read addr 0 → POLL_WAIT.
- POLL_WAIT: idle bus → POLL_CHK.
- POLL_CHK: `readdata[0]`=1 → HOLD, counter reloaded; 0 → LED_CLR.
- LED_CLR: write addr 5, data 1 → ARM.

Bus rules:
- Every bus access is exactly one cycle.
- Outside access cycles: chipselect=0, write_n=1, address=0, writedata=0.

Event FIFO:
- Push while full: the event is dropped, `overflow` sets, `drop_count` increments (saturating).
- Pop and push in the same cycle while full: the pop frees the slot and the push is accepted.
- Pop when `evt_valid`&&`evt_ready`.
- `evt_timestamp` is the head entry; it is don't-care while `evt_valid`=0.

The cycle counter wraps at 2^32 silently.

## Timing
- Reset values:
  - All bus outputs idle as listed above.
  - `evt_valid`=0, `evt_timestamp`=0, `overflow`=0, `drop_count`=0, `busy`=0.
  - FSM in ARM; FIFO empty; cycle counter 0.
- ARM write occurs in the first cycle after reset deassertion.
- `irq` high in IDLE at cycle T:
  - RD_REQ is at T+1.
  - Push is registered at the end of T+3; `evt_valid`=1 from T+4 if the FIFO was empty.
  - Mask write is at T+3; LED_SET is at T+4.
- `irq` is ignored outside IDLE.
- Reset mid-operation:
  - Any bus cycle is abandoned immediately.
  - FIFO contents are lost.
  - ARM is re-executed.
  - The PIO LED state is not cleared by this block.

## Structure
- Shared package holds:
  - the PIO address constants (DATA=0, MASK=2, OUTSET=4, OUTCLR=5);
  - the FSM state enum;
  - the timestamp width constant of 32.
- One sub-module: `evt_fifo`, a synchronous FIFO of `FIFO_DEPTH`×32 with push/pop/full/empty and simultaneous push/pop support. Drop counting is done in the parent.

## Test plan
- Reset release → ARM write on the first cycle: addr 2, writedata 1, write_n=0; then the bus is idle and `busy`=0.
- `irq` rises at T with the BFM returning readdata=1:
  - read addr 0 at T+1;
  - write addr 2 data 0 at T+3;
  - write addr 4 at T+4;
  - `evt_valid` at T+4 with timestamp equal to the counter value at T.
- With `HOLDOFF_CYCLES`=8:
  - pad held high 30 cycles → repeated polls every 11 cycles, no second event;
  - after release → write addr 5 then addr 2 data 1, back to IDLE.
- Spurious irq with readdata=0 → no push, no mask write, FSM back to IDLE at T+4.
- `evt_ready`=0 and 6 hits with `FIFO_DEPTH`=4 → 4 events retained, `overflow`=1, `drop_count`=2. Then `evt_ready`=1 → 4 pops in order of timestamps.
- Assert `reset_n` during HOLD → all outputs reach reset values asynchronously; after release the ARM write is repeated.
